// File: rtl/cc_demux_pkg.sv
// Shared types and constants for the 9-destination write demux.
// Optional broadcast support is enabled by defining CC_DEMUX_BROADCAST_EN.
package cc_demux_pkg;

    localparam int unsigned NUM_DEST = 9;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned CNT_W    = 4;

    localparam logic [SEL_W-1:0] SEL_BROADCAST = 4'hF;

    // SWEEP is only entered when broadcast support is built in.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SWEEP  = 2'd2
    } demuxState_e;

    // True for codes that address a real destination register.
    function automatic logic is_valid_sel(input logic [SEL_W-1:0] sel);
        return (sel < SEL_W'(NUM_DEST));
    endfunction

endpackage

// File: rtl/cc_demux_onehot_dec.sv
// Binary select code to 9-bit one-hot load vector; codes above 8 decode to zero.
module cc_demux_onehot_dec
    import cc_demux_pkg::*;
(
    input  logic [SEL_W-1:0]    code,
    output logic [NUM_DEST-1:0] oneHot
);

    // Compare against every destination index so out-of-range codes yield all zeros.
    always_comb begin
        oneHot = '0;
        for (int unsigned i = 0; i < NUM_DEST; i++) begin
            oneHot[i] = (code == SEL_W'(i));
        end
    end

endmodule

// File: rtl/cc_demuxx_writer.sv
// Write-side demux: accepts {data, selection} and drives a one-hot load strobe
// into the 9-entry register bank, with a sticky flag for illegal codes.
// Define CC_DEMUX_BROADCAST_EN to make selection 4'hF sweep all destinations.
module cc_demuxx_writer
    import cc_demux_pkg::*;
#(
    parameter int unsigned DATAWIDTH_DEMUX_SELECTION = 4,
    parameter int unsigned DATAWIDTH_BUS             = 8,
    parameter int unsigned STROBE_CYCLES             = 1
) (
    input  logic                                 CC_DEMUX_CLOCK_50,
    input  logic                                 CC_DEMUX_RESET_InLow,
    input  logic [DATAWIDTH_BUS-1:0]             CC_DEMUX_data_InBUS,
    input  logic [DATAWIDTH_DEMUX_SELECTION-1:0] CC_DEMUX_selection_InBUS,
    input  logic                                 CC_DEMUX_valid_In,
    input  logic                                 CC_DEMUX_clear_In,
    output logic                                 CC_DEMUX_ready_Out,
    output logic [DATAWIDTH_BUS-1:0]             CC_DEMUX_data_OutBUS,
    output logic [NUM_DEST-1:0]                  CC_DEMUX_load_OutBUS,
    output logic                                 CC_DEMUX_busy_Out,
    output logic                                 CC_DEMUX_error_Out
);

    // Elaboration-time guard on the strobe length, which must fit the 4-bit counter.
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : gBadStrobe
        $error("STROBE_CYCLES must be in 1..15");
    end

    demuxState_e              stateReg, stateNext;
    logic [DATAWIDTH_BUS-1:0] dataReg, dataNext;
    logic [NUM_DEST-1:0]      loadReg, loadNext;
    logic                     busyReg, busyNext;
    logic                     errorReg, errorNext;
    logic [CNT_W-1:0]         cntReg, cntNext;
    logic                     setError;
    logic                     strobeLast;
    logic [SEL_W-1:0]         selCode;
    logic [SEL_W-1:0]         decCode;
    logic [NUM_DEST-1:0]      decOneHot;
`ifdef CC_DEMUX_BROADCAST_EN
    logic [SEL_W-1:0]         idxReg, idxNext;
`endif

    assign selCode    = SEL_W'(CC_DEMUX_selection_InBUS);
    assign strobeLast = (cntReg == CNT_W'(STROBE_CYCLES - 1));

    // Decoder input: the incoming code in IDLE, or the next sweep position.
    always_comb begin
        decCode = selCode;
`ifdef CC_DEMUX_BROADCAST_EN
        if (stateReg == SWEEP) begin
            decCode = SEL_W'(idxReg + 1'b1);
        end else if (selCode == SEL_BROADCAST) begin
            decCode = '0;
        end
`endif
    end

    // One decoder serves both single writes and the broadcast sweep.
    cc_demux_onehot_dec uDec (
        .code   (decCode),
        .oneHot (decOneHot)
    );

    // State register and all registered outputs; reset clears the strobe at once.
    always_ff @(posedge CC_DEMUX_CLOCK_50 or negedge CC_DEMUX_RESET_InLow) begin
        if (!CC_DEMUX_RESET_InLow) begin
            stateReg <= IDLE;
            dataReg  <= '0;
            loadReg  <= '0;
            busyReg  <= 1'b0;
            errorReg <= 1'b0;
            cntReg   <= '0;
`ifdef CC_DEMUX_BROADCAST_EN
            idxReg   <= '0;
`endif
        end else begin
            stateReg <= stateNext;
            dataReg  <= dataNext;
            loadReg  <= loadNext;
            busyReg  <= busyNext;
            errorReg <= errorNext;
            cntReg   <= cntNext;
`ifdef CC_DEMUX_BROADCAST_EN
            idxReg   <= idxNext;
`endif
        end
    end

    // Next-state, strobe timing, data capture and sticky error.
    always_comb begin
        stateNext = stateReg;
        dataNext  = dataReg;
        loadNext  = loadReg;
        cntNext   = cntReg;
        setError  = 1'b0;
`ifdef CC_DEMUX_BROADCAST_EN
        idxNext   = idxReg;
`endif

        case (stateReg)
            IDLE: begin
                if (CC_DEMUX_valid_In) begin
                    if (is_valid_sel(selCode)) begin
                        dataNext  = CC_DEMUX_data_InBUS;
                        loadNext  = decOneHot;
                        cntNext   = '0;
                        stateNext = STROBE;
`ifdef CC_DEMUX_BROADCAST_EN
                    end else if (selCode == SEL_BROADCAST) begin
                        dataNext  = CC_DEMUX_data_InBUS;
                        loadNext  = decOneHot;
                        cntNext   = '0;
                        idxNext   = '0;
                        stateNext = SWEEP;
`endif
                    end else begin
                        // Illegal code: request is consumed, nothing is loaded.
                        setError  = 1'b1;
                    end
                end
            end

            STROBE: begin
                if (strobeLast) begin
                    loadNext  = '0;
                    stateNext = IDLE;
                end else begin
                    cntNext   = CNT_W'(cntReg + 1'b1);
                end
            end

`ifdef CC_DEMUX_BROADCAST_EN
            SWEEP: begin
                if (strobeLast) begin
                    cntNext = '0;
                    if (idxReg == SEL_W'(NUM_DEST - 1)) begin
                        loadNext  = '0;
                        stateNext = IDLE;
                    end else begin
                        idxNext  = SEL_W'(idxReg + 1'b1);
                        loadNext = decOneHot;
                    end
                end else begin
                    cntNext = CNT_W'(cntReg + 1'b1);
                end
            end
`endif

            default: begin
                loadNext  = '0;
                stateNext = IDLE;
            end
        endcase

        // A new error in the same cycle as a clear keeps the flag set.
        if (setError) begin
            errorNext = 1'b1;
        end else if (CC_DEMUX_clear_In) begin
            errorNext = 1'b0;
        end else begin
            errorNext = errorReg;
        end

        busyNext = (stateNext != IDLE);
    end

    assign CC_DEMUX_ready_Out   = (stateReg == IDLE);
    assign CC_DEMUX_data_OutBUS = dataReg;
    assign CC_DEMUX_load_OutBUS = loadReg;
    assign CC_DEMUX_busy_Out    = busyReg;
    assign CC_DEMUX_error_Out   = errorReg;

endmodule
